// File: rtl/io_bus_ctrl.sv
// IO bus controller: decodes a CPU IO load/store into a one-shot device command,
// stalls the CPU until the device acks or a 16-cycle timeout expires.
module io_bus_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        IORead,
  input  logic        IOWrite,
  input  logic [9:0]  io_addr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  dev_ack,
  input  logic [31:0] dev_rdata,
  output logic [3:0]  dev_sel,
  output logic        dev_rd,
  output logic        dev_wr,
  output logic [3:0]  dev_addr,
  output logic [31:0] dev_wdata,
  output logic        stall,
  output logic [31:0] io_rdata,
  output logic        io_err,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ERR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [1:0]  dev_q, dev_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req;

  assign req = IORead | IOWrite;

  // Device handshake: dev_rd/dev_wr is a single-cycle command while dev_sel is held
  // through REQ and WAIT; the selected device answers with a one-cycle dev_ack
  // (plus dev_rdata for reads) in any WAIT cycle. Acks at other times are ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    dev_d   = dev_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = io_addr[3:0];
          wdata_d = io_wdata;
          wr_d    = IOWrite;
          dev_d   = io_addr[5:4];
          // Conflicting read+write proceeds as a write but still flags the error.
          err_d   = IORead & IOWrite;
          if (io_addr[9:6] == 4'd0) begin
            state_d = S_REQ;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_REQ: begin
        cnt_d   = 4'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (dev_ack[dev_q]) begin
          state_d = S_DONE;
          if (!wr_q) rdata_d = dev_rdata;
        end else if (cnt_q == 4'd15) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!wr_q) rdata_d = 32'd0;
        end
      end
      S_ERR: begin
        state_d = S_DONE;
        if (!wr_q) rdata_d = 32'd0;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 4'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      dev_q   <= 2'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      dev_q   <= dev_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  logic busy;
  assign busy = (state_q == S_REQ) || (state_q == S_WAIT);

  assign dev_sel   = busy ? (4'b0001 << dev_q) : 4'b0000;
  assign dev_rd    = (state_q == S_REQ) && !wr_q;
  assign dev_wr    = (state_q == S_REQ) && wr_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign stall     = ((state_q == S_IDLE) && req) || busy || (state_q == S_ERR);
  assign io_rdata  = rdata_q;
  assign io_err    = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: fixed vector table, reset corner sequences, and random
// accesses checked against a transaction-level model of the access rules.
module tb_io_bus_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        IORead, IOWrite;
  logic [9:0]  io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  dev_ack;
  logic [31:0] dev_rdata;
  logic [3:0]  dev_sel;
  logic        dev_rd, dev_wr;
  logic [3:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic        stall;
  logic [31:0] io_rdata;
  logic        io_err;
  logic [2:0]  dbg_state;

  io_bus_ctrl dut (
    .clock(clock), .reset(reset), .IORead(IORead), .IOWrite(IOWrite),
    .io_addr(io_addr), .io_wdata(io_wdata), .dev_ack(dev_ack), .dev_rdata(dev_rdata),
    .dev_sel(dev_sel), .dev_rd(dev_rd), .dev_wr(dev_wr), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .stall(stall), .io_rdata(io_rdata), .io_err(io_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          ack_at;   // WAIT cycle index of the ack, -1 for none
    logic [31:0] rdv;
    logic [3:0]  sel;      // expected one-hot select, 0 when unmapped
    int          lat;      // IDLE..DONE inclusive
    int          err_cnt;
    bit          err_done;
    logic [31:0] rdata;    // io_rdata expected after the access
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome follows from address map, ack timing and direction.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev);
    vec_t r;
    bit   mapped, to;
    int   waits;
    r = v;
    mapped = (v.addr < 10'h040);
    if (mapped) begin
      to         = (v.ack_at < 0) || (v.ack_at > 15);
      waits      = to ? 16 : v.ack_at + 1;
      r.sel      = 4'(1 << int'(v.addr / 16));
      r.lat      = 1 + 1 + waits + 1;
      r.err_cnt  = ((v.rd && v.wr) ? 1 : 0) + (to ? 1 : 0);
      r.err_done = to;
      r.rdata    = v.wr ? prev : (to ? 32'd0 : v.rdv);
    end else begin
      r.sel      = 4'd0;
      r.lat      = 3;
      r.err_cnt  = 1;
      r.err_done = 1'b0;
      r.rdata    = v.wr ? prev : 32'd0;
    end
    return r;
  endfunction

  // driver: one CPU IO instruction, entered and left #1 after a rising edge
  task automatic run_vec(input vec_t v, input string tag);
    int c, lat, rd_n, wr_n, err_n, sel_bad, stall_bad;
    bit done, err_done, busy;
    logic [3:0]  a_seen, noise, exp_sel;
    logic [31:0] w_seen, r_seen;
    c = 0; done = 1'b0; rd_n = 0; wr_n = 0; err_n = 0; sel_bad = 0; stall_bad = 0;
    err_done = 1'b0; a_seen = 4'd0; w_seen = 32'd0; r_seen = 32'd0; lat = 999;
    exp_q.push_back(v.rdata);
    IORead = v.rd; IOWrite = v.wr; io_addr = v.addr; io_wdata = v.wdata;
    while (!done && c < 40) begin
      if (c > 0) begin
        io_addr  = 10'($urandom);
        io_wdata = $urandom;
      end
      noise = 4'($urandom);
      if (v.sel != 4'd0) begin
        noise = noise & ~v.sel;
        if (c < 2 && $urandom_range(0, 1) == 1) noise = noise | v.sel;
        if (v.ack_at >= 0 && c == 2 + v.ack_at) noise = noise | v.sel;
      end
      dev_ack   = noise;
      dev_rdata = (v.ack_at >= 0 && c == 2 + v.ack_at) ? v.rdv : $urandom;
      @(negedge clock);
      busy    = (v.sel != 4'd0) && c >= 1 && c <= v.lat - 2;
      exp_sel = busy ? v.sel : 4'd0;
      if (dev_sel !== exp_sel) sel_bad++;
      if (stall !== (c <= v.lat - 2)) stall_bad++;
      rd_n  += int'(dev_rd);
      wr_n  += int'(dev_wr);
      err_n += int'(io_err);
      if (dev_rd || dev_wr) begin
        a_seen = dev_addr;
        w_seen = dev_wdata;
      end
      if (stall === 1'b0) begin
        done     = 1'b1;
        lat      = c + 1;
        err_done = io_err;
        r_seen   = io_rdata;
      end
      @(posedge clock);
      #1;
      c++;
    end
    IORead = 1'b0; IOWrite = 1'b0; dev_ack = 4'd0;
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " stall_cycles_wrong"}, 32'(stall_bad), 32'd0);
    check({tag, " dev_sel_cycles_wrong"}, 32'(sel_bad), 32'd0);
    check({tag, " dev_rd_pulses"}, 32'(rd_n), (v.sel != 4'd0 && !v.wr) ? 32'd1 : 32'd0);
    check({tag, " dev_wr_pulses"}, 32'(wr_n), (v.sel != 4'd0 && v.wr) ? 32'd1 : 32'd0);
    check({tag, " io_err_pulses"}, 32'(err_n), 32'(v.err_cnt));
    check({tag, " io_err_in_done"}, 32'(err_done), 32'(v.err_done));
    if (v.sel != 4'd0) begin
      check({tag, " dev_addr"}, 32'(a_seen), 32'(v.addr[3:0]));
      check({tag, " dev_wdata"}, w_seen, v.wdata);
    end
    check({tag, " io_rdata"}, r_seen, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0]  = '{1, 0, 10'h010, 32'h0,        0,  32'h0000A5A5, 4'b0010, 4,  0, 0, 32'h0000A5A5};
    tbl[1]  = '{0, 1, 10'h003, 32'h12345678, 5,  32'h0,        4'b0001, 9,  0, 0, 32'h0000A5A5};
    tbl[2]  = '{1, 0, 10'h020, 32'h0,        -1, 32'h0,        4'b0100, 19, 1, 1, 32'h0};
    tbl[3]  = '{1, 0, 10'h031, 32'h0,        15, 32'hDEADBEEF, 4'b1000, 19, 0, 0, 32'hDEADBEEF};
    tbl[4]  = '{1, 0, 10'h3F0, 32'h0,        -1, 32'h0,        4'b0000, 3,  1, 0, 32'h0};
    tbl[5]  = '{0, 1, 10'h030, 32'hCAFEF00D, 2,  32'h0,        4'b1000, 6,  0, 0, 32'h0};
    tbl[6]  = '{1, 0, 10'h010, 32'h0,        1,  32'h00001234, 4'b0010, 5,  0, 0, 32'h00001234};
    tbl[7]  = '{1, 1, 10'h005, 32'h0BAD0BAD, 0,  32'h00000077, 4'b0001, 4,  1, 0, 32'h00001234};
    tbl[8]  = '{0, 1, 10'h040, 32'h00000001, -1, 32'h0,        4'b0000, 3,  1, 0, 32'h00001234};
    tbl[9]  = '{0, 1, 10'h02C, 32'h00000002, -1, 32'h0,        4'b0100, 19, 1, 1, 32'h00001234};
    tbl[10] = '{1, 0, 10'h01F, 32'h0,        3,  32'h5A5A0001, 4'b0010, 7,  0, 0, 32'h5A5A0001};

    reset = 1'b0; IORead = 1'b0; IOWrite = 1'b0; io_addr = 10'd0; io_wdata = 32'd0;
    dev_ack = 4'd0; dev_rdata = 32'd0;
    #2;
    check("rst dev_sel", 32'(dev_sel), 32'd0);
    check("rst strobes", 32'({dev_rd, dev_wr}), 32'd0);
    check("rst io_err", 32'(io_err), 32'd0);
    check("rst io_rdata", io_rdata, 32'd0);
    check("rst dev_wdata", dev_wdata, 32'd0);
    check("rst stall idle", 32'(stall), 32'd0);
    IORead = 1'b1;
    #1;
    check("rst stall with req", 32'(stall), 32'd1);
    IORead = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // table vectors, applied back to back
    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // reset during WAIT aborts the access; a late ack is ignored
    IORead = 1'b1; io_addr = 10'h020;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort dev_sel", 32'(dev_sel), 32'd0);
    check("abort strobes", 32'({dev_rd, dev_wr}), 32'd0);
    check("abort stall with req", 32'(stall), 32'd1);
    check("abort io_rdata", io_rdata, 32'd0);
    IORead = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    dev_ack = 4'hF; dev_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("post_abort%0d outputs", k),
            {dev_sel, dev_rd, dev_wr, stall, io_err}, 32'd0);
      check($sformatf("post_abort%0d io_rdata", k), io_rdata, 32'd0);
    end
    @(posedge clock);
    #1;
    dev_ack = 4'd0;
    model_rdata = 32'd0;
    v = tbl[6];
    v = model(v, model_rdata);
    model_rdata = v.rdata;
    run_vec(v, "after_abort");

    // random accesses against the model
    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 5));
      v.rd    = (k != 1 && k != 2);
      v.wr    = (k == 1 || k == 2 || k == 5);
      v.addr  = ($urandom_range(0, 6) == 0) ? 10'($urandom) : {4'd0, 6'($urandom)};
      v.wdata = $urandom;
      v.rdv   = $urandom;
      v.ack_at = int'($urandom_range(0, 18)) - 1;
      v = model(v, model_rdata);
      model_rdata = v.rdata;
      run_vec(v, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
